// File: rtl/math_adder_seq_pkg.sv
// rtl/math_adder_seq_pkg.sv - shared types and helpers for the sequential multiword adder
package math_adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_seq_state_t;

  // Counter width for n chunks; a single-chunk build still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/math_adder_chunk_cin.sv
// rtl/math_adder_chunk_cin.sv - N-bit a+b+cin built from two carry-less Kogge-Stone slices
module math_adder_chunk_cin #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] sum1;
  logic         c1;
  logic         c2;
  logic [N-1:0] cin_vec;

  always_comb begin
    cin_vec    = '0;
    cin_vec[0] = cin;
  end

  math_adder_kogge_stone_nbit #(.N(N)) u_add_ab (
    .i_a      (a),
    .i_b      (b),
    .ow_sum   (sum1),
    .ow_carry (c1)
  );

  math_adder_kogge_stone_nbit #(.N(N)) u_add_cin (
    .i_a      (sum1),
    .i_b      (cin_vec),
    .ow_sum   (sum),
    .ow_carry (c2)
  );

  // sum1 can only be all-ones when a+b did not carry, so c1 and c2 are exclusive.
  assign cout = c1 | c2;

endmodule

// File: rtl/math_adder_kogge_stone_nbit.sv
// rtl/math_adder_kogge_stone_nbit.sv - N-bit Kogge-Stone parallel-prefix adder, no carry-in
module math_adder_kogge_stone_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] ow_sum,
  output logic         ow_carry
);

  localparam int LEVELS = $clog2(N);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] low_mask;

  // Each level doubles the span; bits below the span already hold final prefixes.
  always_comb begin
    g        = i_a & i_b;
    p        = i_a ^ i_b;
    low_mask = '0;
    for (int l = 0; l < LEVELS; l++) begin
      low_mask = ~({N{1'b1}} << (1 << l));
      g        = g | (p & (g << (1 << l)));
      p        = p & ((p << (1 << l)) | low_mask);
    end
  end

  assign ow_sum   = (i_a ^ i_b) ^ (g << 1);
  assign ow_carry = g[N-1];

endmodule

// File: rtl/math_adder_seq_multiword.sv
// rtl/math_adder_seq_multiword.sv - chunked multi-cycle wide adder; MATH_ADDER_SEQ_OVERFLOW_EN adds o_overflow
module math_adder_seq_multiword
  import math_adder_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHUNK      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_carry
`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
  ,
  output logic                  o_overflow
`endif
);

  localparam int NUM_CHUNKS = (CHUNK > 0) ? DATA_WIDTH / CHUNK : 1;
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);

  if (CHUNK < 1) begin : g_chk_chunk
    $error("math_adder_seq_multiword: CHUNK must be at least 1");
  end else if (DATA_WIDTH % CHUNK != 0) begin : g_chk_div
    $error("math_adder_seq_multiword: DATA_WIDTH must be a multiple of CHUNK");
  end

  adder_seq_state_t      state;
  adder_seq_state_t      state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] sum_reg;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  carry_reg;
  logic                  carry_out_reg;
  logic                  last_chunk;
  logic [CHUNK-1:0]      chunk_sum;
  logic                  chunk_cout;

  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_valid)    state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    if (i_ready)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  math_adder_chunk_cin #(.N(CHUNK)) u_chunk (
    .a    (a_reg[CHUNK-1:0]),
    .b    (b_reg[CHUNK-1:0]),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Result chunks enter at the top so the low chunk lands at bit 0 after the last step.
  if (NUM_CHUNKS == 1) begin : g_sum_single
    assign sum_next = chunk_sum;
  end else begin : g_sum_multi
    assign sum_next = {chunk_sum, sum_reg[DATA_WIDTH-1:CHUNK]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      cnt           <= '0;
    end else if (state == IDLE) begin
      if (i_valid) begin
        a_reg     <= i_a;
        b_reg     <= i_b;
        carry_reg <= i_cin;
        cnt       <= '0;
      end
    end else if (state == RUN) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      sum_reg   <= sum_next;
      carry_reg <= chunk_cout;
      cnt       <= cnt + 1'b1;
      if (last_chunk) begin
        carry_out_reg <= chunk_cout;
      end
    end
  end

  assign o_sum   = sum_reg;
  assign o_carry = carry_out_reg;

`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
  logic a_msb_reg;
  logic b_msb_reg;
  logic overflow_reg;

  // Operand MSBs are shifted out during RUN, so keep copies from the accept cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (state == IDLE) begin
      if (i_valid) begin
        a_msb_reg <= i_a[DATA_WIDTH-1];
        b_msb_reg <= i_b[DATA_WIDTH-1];
      end
    end else if (state == RUN && last_chunk) begin
      overflow_reg <= (a_msb_reg == b_msb_reg) && (chunk_sum[CHUNK-1] != a_msb_reg);
    end
  end

  assign o_overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_math_adder_seq_multiword.sv
// tb/tb_math_adder_seq_multiword.sv - directed self-checking bench for math_adder_seq_multiword
module tb_math_adder_seq_multiword;

  localparam int DW = 32;
  localparam int CH = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_a;
  logic [DW-1:0] i_b;
  logic          i_cin;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_sum;
  logic          o_carry;
`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
  logic          o_overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  math_adder_seq_multiword #(.DATA_WIDTH(DW), .CHUNK(CH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_carry (o_carry)
`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic send(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin);
    check_eq({tag, "_ready"}, 64'(o_ready), 64'd1);
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge i_clk);
      #1;
      lat++;
    end while (!o_valid && lat < 20);
  endtask

  task automatic finish_op(input string tag);
    @(posedge i_clk);
    #1;
    check_eq({tag, "_vdrop"}, 64'(o_valid), 64'd0);
    check_eq({tag, "_rrise"}, 64'(o_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic cin, input logic [DW-1:0] exp_sum, input logic exp_carry);
    int lat;
    send(tag, a, b, cin);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'd4);
    check_eq({tag, "_sum"}, 64'(o_sum), 64'(exp_sum));
    check_eq({tag, "_carry"}, 64'(o_carry), 64'(exp_carry));
    finish_op(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    logic [DW-1:0] held_sum;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_cin   = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_ready", 64'(o_ready), 64'd1);
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_sum", 64'(o_sum), 64'd0);
    check_eq("rst_carry", 64'(o_carry), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    run_op("t1", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1);
    run_op("t2", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0);
    run_op("chain", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0);

    // Backpressure: DONE holds for 5 cycles with outputs frozen.
    i_ready = 1'b0;
    send("t3", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    wait_valid(lat);
    check_eq("t3_lat", 64'(lat), 64'd4);
    check_eq("t3_sum", 64'(o_sum), 64'h1010_1010);
    held_sum = o_sum;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk);
      #1;
      check_eq("t3_hold_valid", 64'(o_valid), 64'd1);
      check_eq("t3_hold_sum", 64'(o_sum), 64'(held_sum));
      check_eq("t3_hold_ready", 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    finish_op("t3");

    // Reset after two chunks have been processed.
    send("t4", 32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check_eq("t4_rst_valid", 64'(o_valid), 64'd0);
    check_eq("t4_rst_sum", 64'(o_sum), 64'd0);
    check_eq("t4_rst_carry", 64'(o_carry), 64'd0);
    check_eq("t4_rst_ready", 64'(o_ready), 64'd1);
    i_rst_n = 1'b1;
    run_op("t4b", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);

    // Second op held on i_valid through RUN/DONE is taken only after the output handshake.
    send("t5", 32'h0000_0100, 32'h0000_0200, 1'b0);
    i_a     = 32'h0000_000A;
    i_b     = 32'h0000_000B;
    i_cin   = 1'b0;
    i_valid = 1'b1;
    wait_valid(lat);
    check_eq("t5_lat1", 64'(lat), 64'd4);
    check_eq("t5_sum1", 64'(o_sum), 64'h300);
    @(posedge i_clk);
    #1;
    check_eq("t5_idle_ready", 64'(o_ready), 64'd1);
    check_eq("t5_idle_valid", 64'(o_valid), 64'd0);
    @(posedge i_clk);
    #1;
    check_eq("t5_acc_ready", 64'(o_ready), 64'd0);
    i_valid = 1'b0;
    wait_valid(lat);
    check_eq("t5_lat2", 64'(lat), 64'd4);
    check_eq("t5_sum2", 64'(o_sum), 64'h15);
    check_eq("t5_carry2", 64'(o_carry), 64'd0);
    finish_op("t5");

`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
    send("t6a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_valid(lat);
    check_eq("t6a_sum", 64'(o_sum), 64'h8000_0000);
    check_eq("t6a_ovf", 64'(o_overflow), 64'd1);
    check_eq("t6a_carry", 64'(o_carry), 64'd0);
    finish_op("t6a");
    send("t6b", 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_valid(lat);
    check_eq("t6b_sum", 64'(o_sum), 64'h0);
    check_eq("t6b_carry", 64'(o_carry), 64'd1);
    check_eq("t6b_ovf", 64'(o_overflow), 64'd1);
    finish_op("t6b");
    send("t6c", 32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_valid(lat);
    check_eq("t6c_ovf", 64'(o_overflow), 64'd0);
    finish_op("t6c");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/math_adder_seq_multiword.md
Name: math_adder_seq_multiword

Overview:
- Multi-cycle wide adder: adds two DATA_WIDTH operands plus carry-in, CHUNK bits per cycle, using the existing N-bit Kogge-Stone adder as its datapath slice.
- Sits directly downstream of `math_adder_kogge_stone_nbit`: registers its ow_sum/ow_carry each cycle and chains the carry across chunks.
- Trades latency for area on wide accumulators and address math.
- Valid/ready handshake on both input and output.

Parameters:
- DATA_WIDTH, 32, total operand/sum width.
- CHUNK, 8, bits processed per cycle (the N of each adder instance).
- NUM_CHUNKS, DATA_WIDTH/CHUNK, derived localparam, not overridable.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_a  input  DATA_WIDTH  operand A.
- i_b  input  DATA_WIDTH  operand B.
- i_cin  input  1  carry-in.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  DATA_WIDTH  A+B+cin, modulo 2^DATA_WIDTH.
- o_carry  output  1  carry-out of bit DATA_WIDTH-1.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous and active-low, sampled on the i_clk rising edge.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_sum=0, o_carry=0, chunk counter=0, carry reg=0.
- Elaboration checks:
  - DATA_WIDTH % CHUNK != 0 is an error ($error).
  - CHUNK < 1 is an error.
  - NUM_CHUNKS=1 is legal: single RUN cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: latch i_a, i_b into operand shift regs; latch i_cin into carry reg; counter=0; go to RUN.
- RUN:
  - o_ready=0, o_valid=0.
  - Each cycle adds the low CHUNK of the A/B regs plus the carry reg.
  - The result chunk shifts into the top of the sum shift reg; the operand regs shift right by CHUNK.
  - Carry reg takes the chunk carry-out; counter increments.
  - When counter==NUM_CHUNKS-1: go to DONE and load o_carry from the chunk carry-out.
- Chunk carry-in: the slice has no cin. It is two adder instances:
  - sum1 = a+b.
  - sum2 = sum1 + {0…,c}.
  - chunk carry = c1|c2 (both never set simultaneously).
- DONE:
  - o_valid=1; o_sum and o_carry are stable.
  - On i_ready: go to IDLE. o_valid drops and o_ready rises on the next cycle. No same-cycle turnaround.
- Latency: handshake at edge E0; o_valid is high after edge E_NUM_CHUNKS (4 cycles at the defaults).
- Throughput: one op per NUM_CHUNKS+2 cycles minimum.
- Input handling:
  - i_valid while o_ready=0 is ignored; operands are not sampled.
  - Inputs may change freely outside the handshake.
- Backpressure: DONE holds indefinitely while i_ready=0, with outputs unchanged.
- Reset mid-operation: abort immediately to reset values; the partial result is discarded.
- Sum register retention:
  - o_sum holds its last value in IDLE until the next DONE.
  - It is rewritten during RUN, but o_valid=0 then, so consumers must qualify with o_valid.

Optional Feature:
- Macro: MATH_ADDER_SEQ_OVERFLOW_EN.
- Defined:
  - Adds port o_overflow (output, 1), the signed two's-complement overflow.
  - Computed as (a_msb==b_msb)&&(sum_msb!=a_msb), with a_msb/b_msb captured at accept.
  - Registered into DONE alongside o_carry; reset 0.
  - Valid only with o_valid.
- Undefined: port and logic are absent; the rest is identical.

Decomposition:
- Package math_adder_seq_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} adder_seq_state_t.
  - Helper function clog2-based counter width.
- Sub-module math_adder_chunk_cin #(N):
  - Combinational a+b+cin built from two math_adder_kogge_stone_nbit instances.
  - Outputs sum[N-1:0] and cout.
  - Top level instantiates one math_adder_chunk_cin with N=CHUNK.

Test Plan (DATA_WIDTH=32, CHUNK=8):
1. i_a=0x0000_0001, i_b=0xFFFF_FFFF, cin=0, i_ready=1 -> o_sum=0x0000_0000, o_carry=1; o_valid exactly 4 cycles after accept.
2. i_a=0x1234_5678, i_b=0x1111_1111, cin=1 -> o_sum=0x2345_678A, o_carry=0.
3. Result with i_ready=0 for 5 cycles in DONE -> o_valid=1, o_sum stable, o_ready=0 throughout. Raising i_ready gives o_valid=0 and o_ready=1 next cycle.
4. Assert i_rst_n=0 during RUN after 2 chunks -> next edge: state IDLE, o_valid=0, o_sum=0, o_carry=0, o_ready=1. Then 0xFFFF_FFFF+0+cin=1 gives o_sum=0, o_carry=1.
5. Send a new op (0xA+0xB) with i_valid held high during RUN/DONE -> only the first op is accepted. The second is accepted in the IDLE cycle after the output handshake and yields o_sum=0x15.
6. With MATH_ADDER_SEQ_OVERFLOW_EN: 0x7FFF_FFFF+0x1 -> o_sum=0x8000_0000, o_overflow=1, o_carry=0. Also 0x8000_0000+0x8000_0000 -> o_sum=0, o_carry=1, o_overflow=1.
